reg_file_mc: RTL and testbench

REG_FILE_MC -- requirements
Module: reg_file_mc

---
 rtl/reg_file_mc_pkg.sv | 6 +
 rtl/dec5t32.sv | 15 +
 rtl/reg_file_mc.sv | 72 +++++++
 tb/tb_reg_file_mc.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/reg_file_mc_pkg.sv
// Shared sizing constants for the multicycle register file.
package reg_file_mc_pkg;
  localparam int REG_W = 32;
  localparam int REG_N = 32;
  localparam int IDX_W = 5;
endpackage

// File: rtl/dec5t32.sv
// 5-to-32 one-hot decoder with enable; all outputs low when en is low.
module dec5t32
  import reg_file_mc_pkg::*;
(
  input  logic               en_i,
  input  logic [IDX_W-1:0]   addr_i,
  output logic [REG_N-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[addr_i] = 1'b1;
  end

endmodule

// File: rtl/reg_file_mc.sv
// 31x32 register file (x0 hardwired to zero) with latched A/B operand registers.
// Define REGFILE_BYPASS_EN to forward same-edge write data into A/B.
module reg_file_mc
  import reg_file_mc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               RegWrite,
  input  logic [IDX_W-1:0]   wt_addr,
  input  logic [REG_W-1:0]   wt_data,
  input  logic [IDX_W-1:0]   rs_addr,
  input  logic [IDX_W-1:0]   rt_addr,
  input  logic               ld_AB,
  output logic [REG_W-1:0]   A,
  output logic [REG_W-1:0]   B,
  input  logic [IDX_W-1:0]   dbg_addr,
  output logic [REG_W-1:0]   dbg_data
);

  logic [REG_W-1:0] regs_q [REG_N];
  logic [REG_N-1:0] we;
  logic [REG_W-1:0] a_q, a_d, b_q, b_d;

  function automatic logic [REG_W-1:0] rd_reg(input logic [IDX_W-1:0] idx);
    return (idx == '0) ? '0 : regs_q[idx];
  endfunction

  dec5t32 u_dec (
    .en_i     (RegWrite),
    .addr_i   (wt_addr),
    .onehot_o (we)
  );

  // Entry 0 is pinned to zero so the decoded write to x0 is discarded.
  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_N; i++) begin
      if (rst || i == 0) regs_q[i] <= '0;
      else if (we[i])    regs_q[i] <= wt_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    a_d = rd_reg(rs_addr);
    b_d = rd_reg(rt_addr);
    if (RegWrite && wt_addr != '0) begin
      if (wt_addr == rs_addr) a_d = wt_data;
      if (wt_addr == rt_addr) b_d = wt_data;
    end
  end
`else
  always_comb begin
    a_d = rd_reg(rs_addr);
    b_d = rd_reg(rt_addr);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (ld_AB) begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign dbg_data = rd_reg(dbg_addr);

endmodule

// File: tb/tb_reg_file_mc.sv
// Scoreboard bench for reg_file_mc: driver pushes model expectations, monitor compares at negedge.
module tb_reg_file_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWrite = 1'b0;
  logic [4:0]  wt_addr = '0;
  logic [31:0] wt_data = '0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic        ld_AB = 1'b0;
  logic [31:0] A, B;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] dbg;
    int          tag;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem [32];
  logic [31:0] ma, mb;
  int          step = 0;

  reg_file_mc dut (
    .clk      (clk),
    .rst      (rst),
    .RegWrite (RegWrite),
    .wt_addr  (wt_addr),
    .wt_data  (wt_data),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .ld_AB    (ld_AB),
    .A        (A),
    .B        (B),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  // Monitor: one expectation per driven cycle, sampled mid-low phase.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (A !== e.a) begin
        errors++;
        $display("FAIL A step=%0d got=%h exp=%h", e.tag, A, e.a);
      end
      checks++;
      if (B !== e.b) begin
        errors++;
        $display("FAIL B step=%0d got=%h exp=%h", e.tag, B, e.b);
      end
      checks++;
      if (dbg_data !== e.dbg) begin
        errors++;
        $display("FAIL dbg step=%0d got=%h exp=%h", e.tag, dbg_data, e.dbg);
      end
    end
  end

  // Reference: pre-write read, optional forwarding, then commit the write.
  task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ld, input logic [4:0] dbg);
    logic [31:0] ra, rb;
    exp_t e;
    rst = r; RegWrite = we; wt_addr = wa; wt_data = wd;
    rs_addr = rs; rt_addr = rt; ld_AB = ld; dbg_addr = dbg;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      ma = 32'h0;
      mb = 32'h0;
    end else begin
      ra = mem[rs];
      rb = mem[rt];
`ifdef REGFILE_BYPASS_EN
      if (we && wa != 5'd0 && wa == rs) ra = wd;
      if (we && wa != 5'd0 && wa == rt) rb = wd;
`endif
      if (ld) begin
        ma = ra;
        mb = rb;
      end
      if (we && wa != 5'd0) mem[wa] = wd;
    end
    e.a = ma; e.b = mb; e.dbg = mem[dbg]; e.tag = step;
    sb_q.push_back(e);
    step++;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] dbg);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, dbg);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    ma = 32'h0;
    mb = 32'h0;
    @(negedge clk); #1;

    // Reset after random writes, then sweep dbg over every index.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    for (int i = 0; i < 20; i++)
      drive(1'b0, 1'b1, 5'($urandom_range(0, 31)), $urandom, 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 1'b1, 5'($urandom_range(0, 31)));
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    for (int i = 0; i < 32; i++) idle(5'(i));

    // Write x5 then read it on A, x0 on B.
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 5'd5);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b1, 5'd0);

    // x0 write is discarded; remaining registers untouched.
    for (int i = 1; i < 32; i++) drive(1'b0, 1'b1, 5'(i), 32'h100 + i, 5'd0, 5'd0, 1'b0, 5'(i));
    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0);
    for (int i = 0; i < 32; i++) idle(5'(i));

    // Same-edge write/latch hazard on x7, both ports.
    drive(1'b0, 1'b1, 5'd7, 32'h11, 5'd0, 5'd0, 1'b0, 5'd7);
    drive(1'b0, 1'b1, 5'd7, 32'h22, 5'd7, 5'd7, 1'b1, 5'd7);
    drive(1'b0, 1'b1, 5'd0, 32'h33, 5'd0, 5'd0, 1'b1, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b1, 5'd7);

    // Hold A/B across writes, then reset beats a write to x3.
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1, 5'(i + 7), $urandom, 5'(i + 7), 5'(i + 8), 1'b0, 5'(i + 7));
    drive(1'b1, 1'b1, 5'd3, 32'h55, 5'd3, 5'd3, 1'b1, 5'd3);
    idle(5'd3);
    drive(1'b0, 1'b1, 5'd3, 32'h66, 5'd0, 5'd0, 1'b0, 5'd3);

    // Sweep: x[i] = i*0x01010101, read back on A/B and dbg.
    for (int i = 1; i < 32; i++) drive(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0, 1'b0, 5'(i));
    for (int i = 0; i < 32; i++) drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b1, 5'(i));

    // Random traffic with narrow address range to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa, rs, rt;
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      rs = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      rt = ($urandom_range(0, 1) == 0) ? rs : 5'($urandom_range(0, 3));
      drive(($urandom_range(0, 49) == 0), 1'($urandom), wa, $urandom, rs, rt,
            1'($urandom), 5'($urandom_range(0, 31)));
    end

    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
